fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2, the instruction-queue depth in entries; fixed at 2 for this revision.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 AnyStall  in  1  pipeline stall; the decode stage does not consume the IF-stage instruction this cycle.
REQ-006 Jump_IDM1  in  1  the instruction at the head of IF decodes as J/JAL.
REQ-007 JumpTgt_IDM1  in  26  jump target index from that instruction.
REQ-008 ExRedirect_EX  in  1  a branch resolved taken in EX.
REQ-009 ExRedirectPc_EX  in  32  the branch target PC.
REQ-010 ImemReq  out  1  instruction-memory request; held until acknowledged.
REQ-011 ImemAddr  out  32  fetch address; word aligned; stable while ImemReq=1 and ImemAck=0.
REQ-012 ImemAck  in  1  request accepted; ImemData is valid in this same cycle.
REQ-013 ImemData  in  32  instruction word.
REQ-014 Pc_IF  out  32  PC of the queue-head instruction.
REQ-015 FetchData_IF  out  32  queue-head instruction word.
REQ-016 InstrVal_IF  out  1  queue head is valid.

Function
REQ-017 A fetch PC register (FPc) shall hold the next address to request and advance by 4 on every ImemAck accepted in state REQ.
REQ-018 States shall be IDLE, REQ and DRAIN. IDLE->REQ when the queue has a free slot. REQ->IDLE on ImemAck when the queue would become full. REQ->DRAIN on a redirect without ImemAck. DRAIN->IDLE on ImemAck.
REQ-019 In REQ and DRAIN, ImemReq=1. In IDLE, ImemReq=0.
REQ-020 At most one request shall be outstanding; a new request shall issue only if the queue has a slot free after the pending consumption.
REQ-021 On ImemAck in REQ with no redirect, {ImemAddr, ImemData} shall be written to the queue tail.
REQ-022 On ImemAck in DRAIN, the data shall be discarded and not queued.
REQ-023 The queue head shall drive Pc_IF, FetchData_IF and InstrVal_IF directly from registers, with zero combinational path from ImemData.
REQ-024 The head shall be popped when InstrVal_IF=1 and AnyStall=0.
REQ-025 A queue write and a pop in the same cycle shall both occur; occupancy is unchanged.
REQ-026 A write to an empty queue shall appear at the head on the next cycle; there is no same-cycle bypass.
REQ-027 The jump is taken when Jump_IDM1=1, InstrVal_IF=1 and AnyStall=0. Jump target = {Pc_IF[31:28]+carry from Pc_IF+4, i.e. (Pc_IF+4)[31:28], JumpTgt_IDM1, 2'b00}.
REQ-028 The EX redirect shall be taken whenever ExRedirect_EX=1, regardless of AnyStall, and shall have priority over a simultaneous jump.
REQ-029 On any redirect, FPc shall load the target, all queue entries after the head shall be flushed, and the head shall also be flushed on an EX redirect (a jump pops its own head normally).
REQ-030 After a redirect, InstrVal_IF shall be 0 on the next cycle. The first target instruction shall reach the head no earlier than 2 cycles after the redirect cycle.
REQ-031 A redirect in the same cycle as ImemAck in REQ shall discard that data, and the next request shall use the target.
REQ-032 There is no branch delay slot; fall-through words fetched after a taken jump or branch shall never reach InstrVal_IF=1.

Reset
REQ-033 While reset=1: FPc=RESET_PC, state=IDLE, queue empty, ImemReq=0, InstrVal_IF=0, Pc_IF=0, FetchData_IF=0.
REQ-034 Reset shall override a concurrent redirect or ack; an ack arriving in the reset cycle shall be discarded.
REQ-035 The first request with ImemAddr=RESET_PC shall assert the cycle after reset deasserts.

Structure
REQ-036 RESET_PC default, state encodings and the jump-target width shall live in the shared MIPS constants include.
REQ-037 The queue shall be a sub-module fetch_fifo: {pc,instr} entries, push/pop/flush_tail/flush_all, full/empty outputs.

Verification
REQ-038 Reset, memory acks every cycle, AnyStall=0 -> Pc_IF sequence 0,4,8,C on consecutive cycles; first valid head 2 cycles after reset release.
REQ-039 AnyStall=1 for 5 cycles with the queue full -> ImemReq=0; Pc_IF held at its value; no word lost or duplicated after release.
REQ-040 J at Pc_IF=0x0040_0010 with JumpTgt=0x0000100 -> next request ImemAddr=0x0000_0400; PCs 0x14/0x18 are never valid.
REQ-041 ExRedirect_EX with PC 0x0000_0200 while a request is pending and the ack is delayed 3 cycles -> state DRAIN; the stale word is dropped; next ImemAddr=0x200.
REQ-042 ExRedirect_EX and a taken jump in the same cycle -> the EX target wins.
REQ-043 reset asserted mid-DRAIN with a simultaneous ack -> all outputs reach their reset values next cycle; the refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, state encoding and queue entry type.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          JTGT_W           = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // J/JAL target: region bits come from the sequential PC, not the jump's own PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [JTGT_W-1:0] idx);
    return {4'((pc + 32'd4) >> 28), idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue of {pc,instr}; head is a pure register read.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_tail_i,
  input  logic      flush_all_i,
  input  fq_entry_t wdata_i,
  output fq_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Pointer wrap relies on DEPTH being a power of two.
  fq_entry_t      mem_q [DEPTH];
  logic [PW-1:0]  rd_q, wr_q;
  logic [CW-1:0]  cnt_q;

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_all_i) begin
      wr_q  <= rd_q;
      cnt_q <= '0;
    end else if (flush_tail_i) begin
      // Keep only the head, unless it is being consumed this cycle too.
      if (pop_i) begin
        rd_q  <= rd_q + PW'(1);
        wr_q  <= rd_q + PW'(1);
        cnt_q <= '0;
      end else if (!empty_o) begin
        wr_q  <= rd_q + PW'(1);
        cnt_q <= CW'(1);
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requester feeding a 2-entry queue,
// with J/JAL and EX-branch redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AnyStall,
  input  logic              Jump_IDM1,
  input  logic [JTGT_W-1:0] JumpTgt_IDM1,
  input  logic              ExRedirect_EX,
  input  logic [31:0]       ExRedirectPc_EX,
  output logic              ImemReq,
  output logic [31:0]       ImemAddr,
  input  logic              ImemAck,
  input  logic [31:0]       ImemData,
  output logic [31:0]       Pc_IF,
  output logic [31:0]       FetchData_IF,
  output logic              InstrVal_IF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  daddr_q, daddr_d;

  fq_entry_t head, wdata;
  logic      empty, full, pop, push, jmp, redirect;
  logic [31:0] redir_pc;

  assign InstrVal_IF  = !empty;
  assign Pc_IF        = head.pc;
  assign FetchData_IF = head.instr;

  assign pop      = !empty && !AnyStall;
  assign jmp      = Jump_IDM1 && pop && !ExRedirect_EX;
  assign redirect = ExRedirect_EX || jmp;
  assign redir_pc = ExRedirect_EX ? ExRedirectPc_EX : jump_target(head.pc, JumpTgt_IDM1);
  assign wdata    = '{pc: fpc_q, instr: ImemData};

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .flush_tail_i (jmp),
    .flush_all_i  (ExRedirect_EX),
    .wdata_i      (wdata),
    .head_o       (head),
    .empty_o      (empty),
    .full_o       (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      daddr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    daddr_d  = daddr_q;
    push     = 1'b0;
    ImemReq  = 1'b0;
    ImemAddr = fpc_q;
    case (state_q)
      ST_IDLE: begin
        // A redirect empties the queue, so a slot is guaranteed.
        if (redirect || !full || pop) state_d = ST_REQ;
      end
      ST_REQ: begin
        ImemReq = 1'b1;
        if (ImemAck) begin
          fpc_d = fpc_q + 32'd4;
          if (!redirect) begin
            push = 1'b1;
            if (!empty && !pop) state_d = ST_IDLE;
          end
        end else if (redirect) begin
          // The in-flight address must stay on the bus until it is acked.
          state_d = ST_DRAIN;
          daddr_d = fpc_q;
        end
      end
      ST_DRAIN: begin
        ImemReq  = 1'b1;
        ImemAddr = daddr_q;
        if (ImemAck) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) fpc_d = redir_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: architectural PC-stream scoreboard plus directed scenarios
// and a randomized phase.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        AnyStall = 1'b0;
  logic        Jump_IDM1 = 1'b0;
  logic [25:0] JumpTgt_IDM1 = '0;
  logic        ExRedirect_EX = 1'b0;
  logic [31:0] ExRedirectPc_EX = '0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = '0;
  logic [31:0] Pc_IF, FetchData_IF;
  logic        InstrVal_IF;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .AnyStall(AnyStall), .Jump_IDM1(Jump_IDM1),
    .JumpTgt_IDM1(JumpTgt_IDM1), .ExRedirect_EX(ExRedirect_EX),
    .ExRedirectPc_EX(ExRedirectPc_EX), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemData(ImemData), .Pc_IF(Pc_IF),
    .FetchData_IF(FetchData_IF), .InstrVal_IF(InstrVal_IF)
  );

  int n_chk = 0, n_pass = 0, consumed = 0;

  // Reference model state: next PC the program must present at the head.
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] prev_addr = '0;
  bit rst_prev = 1'b1, redir_prev = 1'b0, pend_prev = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick(input bit rst, input bit stall, input bit ack_en, input bit jmp,
                      input logic [25:0] jt, input bit exr, input logic [31:0] epc);
    logic [31:0] nxt;
    @(negedge clk);
    if (rst_prev) begin
      chk("rst_req", ImemReq, 0);
      chk("rst_val", InstrVal_IF, 0);
      chk("rst_pc", Pc_IF, 0);
      chk("rst_data", FetchData_IF, 0);
    end else begin
      if (redir_prev) chk("redir_bubble", InstrVal_IF, 0);
      if (pend_prev) begin
        chk("req_hold", ImemReq, 1);
        chk("addr_hold", ImemAddr, prev_addr);
      end
      if (ImemReq) chk("addr_align", ImemAddr[1:0], 0);
      if (InstrVal_IF) begin
        chk("head_pc", Pc_IF, exp_pc);
        chk("head_data", FetchData_IF, memf(Pc_IF));
      end
    end
    reset           = rst;
    AnyStall        = stall;
    ImemAck         = ack_en && ImemReq;
    ImemData        = ImemAck ? memf(ImemAddr) : 32'hDEAD_BEEF;
    Jump_IDM1       = jmp;
    JumpTgt_IDM1    = jt;
    ExRedirect_EX   = exr;
    ExRedirectPc_EX = epc;
    rst_prev   = rst;
    redir_prev = 1'b0;
    pend_prev  = !rst && ImemReq && !ImemAck;
    prev_addr  = ImemAddr;
    if (rst) exp_pc = RST_PC;
    else if (exr) begin
      exp_pc = epc;
      redir_prev = 1'b1;
    end else if (InstrVal_IF && !stall) begin
      nxt = Pc_IF + 32'd4;
      if (jmp) begin
        exp_pc = {nxt[31:28], jt, 2'b00};
        redir_prev = 1'b1;
      end else exp_pc = nxt;
      consumed++;
    end
  endtask

  task automatic idle_tick(input bit stall, input bit ack_en);
    tick(0, stall, ack_en, 0, '0, 0, '0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30; i++) begin
      idle_tick(1, 1);
      if (InstrVal_IF) break;
    end
    chk(tag, InstrVal_IF, 1);
  endtask

  task automatic wait_req_noack(input string tag);
    for (int i = 0; i < 30; i++) begin
      idle_tick(0, 0);
      if (ImemReq) break;
    end
    chk(tag, ImemReq, 1);
  endtask

  initial begin
    logic [31:0] hold, stale;
    int c0;
    // Reset with a concurrent redirect/jump attempt: reset must win.
    repeat (3) tick(1, 0, 1, 1, 26'h155, 1, 32'h500);
    tick(0, 0, 1, 0, '0, 0, '0);
    idle_tick(0, 1);
    chk("first_req", ImemReq, 1);
    chk("first_addr", ImemAddr, RST_PC);
    idle_tick(0, 1); chk("seq0", Pc_IF, 32'h0);
    idle_tick(0, 1); chk("seq4", Pc_IF, 32'h4);
    idle_tick(0, 1); chk("seq8", Pc_IF, 32'h8);
    idle_tick(0, 1); chk("seqC", Pc_IF, 32'hC);

    // Full queue under a long stall.
    repeat (6) idle_tick(1, 1);
    hold = Pc_IF;
    chk("stall_val", InstrVal_IF, 1);
    for (int i = 0; i < 5; i++) begin
      idle_tick(1, 1);
      chk("stall_req", ImemReq, 0);
      chk("stall_pc", Pc_IF, hold);
    end
    repeat (10) idle_tick(0, 1);

    // J from 0x0040_0010 to index 0x100.
    tick(0, 1, 1, 0, '0, 1, 32'h0040_0010);
    wait_valid("w_j_head");
    chk("j_head", Pc_IF, 32'h0040_0010);
    tick(0, 0, 1, 1, 26'h100, 0, '0);
    idle_tick(0, 1);
    chk("j_req", ImemReq, 1);
    chk("j_addr", ImemAddr, 32'h0000_0400);
    wait_valid("w_j_tgt");
    chk("j_first", Pc_IF, 32'h0000_0400);

    // EX redirect and jump together: EX target wins.
    tick(0, 0, 1, 1, 26'h3FF, 1, 32'h0000_0300);
    idle_tick(0, 1);
    chk("pri_req", ImemReq, 1);
    chk("pri_addr", ImemAddr, 32'h0000_0300);
    wait_valid("w_pri");
    chk("pri_first", Pc_IF, 32'h0000_0300);

    // EX redirect with the pending ack delayed 3 cycles.
    wait_req_noack("w_dr_req");
    stale = ImemAddr;
    tick(0, 0, 0, 0, '0, 1, 32'h0000_0200);
    idle_tick(0, 0);
    chk("dr_req", ImemReq, 1);
    chk("dr_addr", ImemAddr, stale);
    idle_tick(0, 0);
    idle_tick(0, 1);
    for (int i = 0; i < 10; i++) begin
      idle_tick(0, 1);
      if (ImemReq) break;
    end
    chk("dr_new", ImemAddr, 32'h0000_0200);
    wait_valid("w_dr");
    chk("dr_first", Pc_IF, 32'h0000_0200);

    // Jump whose sequential PC carries into the region bits.
    tick(0, 1, 1, 0, '0, 1, 32'h1FFF_FFFC);
    wait_valid("w_cy");
    tick(0, 0, 1, 1, 26'h10, 0, '0);
    wait_valid("w_cy_tgt");
    chk("carry_tgt", Pc_IF, 32'h2000_0040);

    // Reset mid-DRAIN with a concurrent ack.
    wait_req_noack("w_rd_req");
    tick(0, 0, 0, 0, '0, 1, 32'h0000_0600);
    idle_tick(0, 0);
    chk("rd_drain", ImemReq, 1);
    tick(1, 0, 1, 0, '0, 0, '0);
    idle_tick(0, 1);
    idle_tick(0, 1);
    chk("rd_req", ImemReq, 1);
    chk("rd_addr", ImemAddr, RST_PC);
    wait_valid("w_rd");
    chk("rd_first", Pc_IF, RST_PC);

    // Randomized traffic against the PC-stream model.
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_st, r_ack, r_j, r_ex;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 499) == 0);
      r_st  = ($urandom_range(0, 9) < 3);
      r_ack = ($urandom_range(0, 9) < 6);
      r_j   = ($urandom_range(0, 9) == 0);
      r_ex  = ($urandom_range(0, 29) == 0);
      r_pc  = ($urandom_range(0, 7) == 0) ? 32'h1FFF_FFF8
                                          : 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
      tick(r_rst, r_st, r_ack, r_j, 26'($urandom_range(0, 4095)), r_ex, r_pc);
    end
    chk("progress", 32'(consumed - c0 > 200), 1);
    idle_tick(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
